imem_boot_loader: RTL and testbench

- Byte-stream boot loader in front of the single-cycle core.
- Receives a length-prefixed program image over a valid/ready byte interface, assembles little-endian 32-bit words and writes them sequentially into instruction memory.
- Drives the core's active-low reset: holds the core in reset until the image is fully written, then releases it, replacing the bench-driven rst sequencing.

---
 rtl/imem_boot_loader_if.sv | 30 +++
 rtl/imem_boot_loader.sv | 151 +++++++++++++++
 tb/tb_imem_boot_loader.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_boot_loader_if.sv
// ============================================================================
// imem_boot_loader_if : byte-stream input and imem write port of the loader
// Revision 1.0
// ============================================================================
`default_nettype none

interface imem_boot_loader_if #(
  parameter int ADDR_WIDTH = 10
);
  logic [7:0]            rx_data;
  logic                  rx_valid;
  logic                  rx_ready;
  logic                  imem_we;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic [31:0]           imem_wdata;

  // Byte source and memory sink side
  modport master (
    output rx_data, rx_valid,
    input  rx_ready, imem_we, imem_addr, imem_wdata
  );

  // Loader side
  modport slave (
    input  rx_data, rx_valid,
    output rx_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

`default_nettype wire

// File: rtl/imem_boot_loader.sv
// ============================================================================
// imem_boot_loader : loads a length-prefixed LE word image into imem, then
// releases the core reset. Revision 1.0
// ============================================================================
`default_nettype none

module imem_boot_loader #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                clk,
  input  logic                rst,
  imem_boot_loader_if.slave   bus,
  output logic                core_rst,
  output logic                done,
  output logic                error
);

  localparam logic [16:0] CAPACITY = 17'(1) << ADDR_WIDTH;

  typedef enum logic [2:0] {
    S_LEN_LO = 3'd0,
    S_LEN_HI = 3'd1,
    S_DATA   = 3'd2,
    S_WRITE  = 3'd3,
    S_RUN    = 3'd4,
    S_ERR    = 3'd5
  } state_t;

  state_t                state_q, state_d;
  logic [15:0]           len_q, len_d;
  logic [1:0]            byte_idx_q, byte_idx_d;
  logic [ADDR_WIDTH-1:0] word_idx_q, word_idx_d;
  logic [31:0]           word_q, word_d;
  logic                  imem_we_q, imem_we_d;
  logic [ADDR_WIDTH-1:0] imem_addr_q, imem_addr_d;
  logic [31:0]           imem_wdata_q, imem_wdata_d;
  logic                  core_rst_q, core_rst_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;

  logic                  rx_ready_w;
  logic                  accept_w;
  logic [15:0]           len_new_w;

  // rst gates ready combinationally so nothing is offered during reset
  assign rx_ready_w = rst && ((state_q == S_LEN_LO) || (state_q == S_LEN_HI) ||
                              (state_q == S_DATA));
  assign accept_w   = bus.rx_valid && rx_ready_w;
  assign len_new_w  = {bus.rx_data, len_q[7:0]};

  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    byte_idx_d   = byte_idx_q;
    word_idx_d   = word_idx_q;
    word_d       = word_q;
    imem_we_d    = 1'b0;
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;

    case (state_q)
      S_LEN_LO: begin
        if (accept_w) begin
          len_d[7:0] = bus.rx_data;
          state_d    = S_LEN_HI;
        end
      end
      S_LEN_HI: begin
        if (accept_w) begin
          len_d[15:8] = bus.rx_data;
          if (len_new_w == 16'd0) begin
            state_d = S_RUN;
          end else if ({1'b0, len_new_w} > CAPACITY) begin
            state_d = S_ERR;
          end else begin
            state_d    = S_DATA;
            byte_idx_d = 2'd0;
            word_idx_d = '0;
          end
        end
      end
      S_DATA: begin
        if (accept_w) begin
          word_d[{byte_idx_q, 3'b000} +: 8] = bus.rx_data;
          byte_idx_d = byte_idx_q + 2'd1;
          // Fourth byte: register the strobe now so it is seen in WRITE
          if (byte_idx_q == 2'd3) begin
            state_d      = S_WRITE;
            imem_we_d    = 1'b1;
            imem_addr_d  = word_idx_q;
            imem_wdata_d = {bus.rx_data, word_q[23:0]};
          end
        end
      end
      S_WRITE: begin
        if ((17'(word_idx_q) + 17'd1) == {1'b0, len_q}) begin
          state_d = S_RUN;
        end else begin
          word_idx_d = word_idx_q + 1'b1;
          state_d    = S_DATA;
        end
      end
      S_RUN:   state_d = S_RUN;
      S_ERR:   state_d = S_ERR;
      default: state_d = S_LEN_LO;
    endcase

    core_rst_d = (state_d == S_RUN);
    done_d     = (state_d == S_RUN);
    error_d    = (state_d == S_ERR);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_LEN_LO;
      len_q        <= 16'd0;
      byte_idx_q   <= 2'd0;
      word_idx_q   <= '0;
      word_q       <= 32'd0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= 32'd0;
      core_rst_q   <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      byte_idx_q   <= byte_idx_d;
      word_idx_q   <= word_idx_d;
      word_q       <= word_d;
      imem_we_q    <= imem_we_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
      core_rst_q   <= core_rst_d;
      done_q       <= done_d;
      error_q      <= error_d;
    end
  end

  assign bus.rx_ready   = rx_ready_w;
  assign bus.imem_we    = imem_we_q;
  assign bus.imem_addr  = imem_addr_q;
  assign bus.imem_wdata = imem_wdata_q;
  assign core_rst       = core_rst_q;
  assign done           = done_q;
  assign error          = error_q;

endmodule

`default_nettype wire

// File: tb/tb_imem_boot_loader.sv
// ============================================================================
// tb_imem_boot_loader : random image streams checked by a write scoreboard
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_imem_boot_loader;

  localparam int AW  = 4;
  localparam int CAP = 1 << AW;

  typedef logic [7:0] bq_t[$];
  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  logic clk = 1'b0;
  logic rst;
  logic core_rst, done, error;

  always #5 clk = ~clk;

  imem_boot_loader_if #(.ADDR_WIDTH(AW)) bus ();

  imem_boot_loader #(.ADDR_WIDTH(AW)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .core_rst (core_rst),
    .done     (done),
    .error    (error)
  );

  wr_t exp_q[$];
  wr_t mon_e;
  int  n_cmp = 0;
  int  n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every write strobe must match the next expected word
  always @(negedge clk) begin
    if (rst === 1'b1 && bus.imem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h expected no write",
                 bus.imem_addr, bus.imem_wdata);
      end else begin
        mon_e = exp_q.pop_front();
        check("write_addr_data", {28'd0, bus.imem_addr, bus.imem_wdata}, {28'd0, mon_e.addr, mon_e.data});
        check("rx_ready_in_write", {63'd0, bus.rx_ready}, 64'd0);
      end
    end
  end

  // Reference model: kind 0 = data image, 1 = empty image, 2 = too long
  task automatic expect_image(input bq_t img, input int sent, output int kind);
    int n;
    n = {img[1], img[0]};
    if (n == 0)        kind = 1;
    else if (n > CAP)  kind = 2;
    else begin
      kind = 0;
      for (int i = 0; i < n; i++) begin
        if (2 + 4*i + 3 < sent) begin
          wr_t w;
          w.addr = AW'(i);
          w.data = {img[2+4*i+3], img[2+4*i+2], img[2+4*i+1], img[2+4*i]};
          exp_q.push_back(w);
        end
      end
    end
  endtask

  task automatic build_image(input int n, output bq_t q);
    q = {};
    q.push_back(8'(n));
    q.push_back(8'(n >> 8));
    if (n >= 1 && n <= CAP)
      for (int i = 0; i < 4*n; i++) q.push_back(8'($urandom));
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int  n;
    int  g;
    bit  acc;
    g = 0;
    if (gaps) begin
      while ($urandom_range(0, 1) == 1 && g < 8) begin
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'($urandom);
        @(posedge clk); #1;
        g++;
      end
    end
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    n = 0;
    do begin
      @(negedge clk);
      acc = bus.rx_ready;
      @(posedge clk); #1;
      n++;
    end while (!acc && n < 64);
    if (!acc) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_timeout: got no rx_ready in %0d cycles expected acceptance", n);
    end
    bus.rx_valid = 1'b0;
  endtask

  task automatic do_reset(input int cycles);
    rst          = 1'b0;
    bus.rx_valid = 1'b1;
    bus.rx_data  = 8'hA5;
    repeat (cycles) begin
      @(negedge clk);
      check("reset_outputs", {59'd0, bus.rx_ready, core_rst, bus.imem_we, done, error}, 64'd0);
    end
    @(posedge clk); #1;
    rst          = 1'b1;
    bus.rx_valid = 1'b0;
  endtask

  // Status after the last byte: timing of done/core_rst/error edges
  task automatic run_image(input bq_t img, input bit gaps, output int kind);
    expect_image(img, img.size(), kind);
    foreach (img[i]) send_byte(img[i], gaps);
    case (kind)
      0: begin
        @(negedge clk);
        check("pre_run", {60'd0, done, core_rst, error, bus.imem_we}, 64'b0001);
        @(negedge clk);
        check("run_entry", {60'd0, done, core_rst, error, bus.rx_ready}, 64'b1100);
      end
      1: begin
        @(negedge clk);
        check("run_empty", {59'd0, done, core_rst, error, bus.rx_ready, bus.imem_we}, 64'b11000);
      end
      default: begin
        @(negedge clk);
        check("err_entry", {60'd0, done, core_rst, error, bus.rx_ready}, 64'b0010);
      end
    endcase
    @(posedge clk); #1;
  endtask

  task automatic poke_idle(input int cycles, input logic [2:0] status);
    repeat (cycles) begin
      bus.rx_valid = 1'b1;
      bus.rx_data  = 8'($urandom);
      @(negedge clk);
      check("terminal_hold", {59'd0, bus.rx_ready, bus.imem_we, done, core_rst, error},
            {59'd0, 2'b00, status});
      @(posedge clk); #1;
    end
    bus.rx_valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no end of test expected $finish before timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    bq_t img, img_gap;
    int  kind;
    rst          = 1'b0;
    bus.rx_valid = 1'b1;
    bus.rx_data  = 8'h00;

    do_reset(3);
    check("reset_bus", {28'd0, bus.imem_addr, bus.imem_wdata}, 64'd0);

    img = '{8'h02, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'h93, 8'h05, 8'h30, 8'h00};
    run_image(img, 1'b0, kind);
    poke_idle(4, 3'b110);

    do_reset(2);
    img = '{8'h00, 8'h00};
    run_image(img, 1'b0, kind);
    poke_idle(2, 3'b110);

    do_reset(1);
    img = '{8'h11, 8'h00};
    run_image(img, 1'b0, kind);
    poke_idle(3, 3'b001);

    // Full-capacity image: last write lands on the all-ones address
    do_reset(1);
    build_image(CAP, img);
    run_image(img, 1'b0, kind);

    // Same image with and without rx_valid gaps
    do_reset(1);
    build_image(3, img);
    img_gap = img;
    run_image(img, 1'b0, kind);
    do_reset(1);
    run_image(img_gap, 1'b1, kind);

    // Aborted streams: the 6-byte one completes word 0, the 5-byte one does not
    do_reset(1);
    build_image(3, img);
    expect_image(img, 6, kind);
    for (int i = 0; i < 6; i++) send_byte(img[i], 1'b0);
    repeat (3) @(posedge clk);
    #1;
    do_reset(1);
    build_image(2, img);
    expect_image(img, 5, kind);
    for (int i = 0; i < 5; i++) send_byte(img[i], 1'b0);
    repeat (3) @(posedge clk);
    #1;
    do_reset(1);
    img = '{8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    run_image(img, 1'b0, kind);

    for (int r = 0; r < 6; r++) begin
      do_reset(1);
      build_image(int'($urandom_range(0, CAP + 2)), img);
      run_image(img, 1'($urandom_range(0, 1)), kind);
      poke_idle(2, (kind == 2) ? 3'b001 : 3'b110);
    end

    repeat (4) @(posedge clk);
    #1;
    check("pending_writes", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
